// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

  // Arbiter control state: free arbitration or port 1 holding a lock.
  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Port indices, also used as the round-robin pointer value.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam int DMEM_WORDS    = 256;
  localparam int ADDR_BITS_DEF = 10;
  localparam int MAX_LOCK_DEF  = 16;

  // Request fields of whichever port currently owns the memory.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        legal;
  } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the word memory.
interface dmem_arbiter_if;

  // Port 0: CPU load/store path.
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_err;

  // Port 1: secondary master with optional lock.
  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_lock;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_err;

  // Memory side.
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Requesters plus memory: drive requests and read data, observe the rest.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_addr_check.sv
// Combinational legality test: word aligned and inside the memory window.
module dmem_addr_check
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic [31:0] addr,
  output logic        legal
);

  // Bits allowed to be set: inside the window and above the byte offset.
  localparam logic [31:0] WINDOW_MASK = 32'((64'd1 << ADDR_BITS) - 64'd1);
  localparam logic [31:0] LEGAL_MASK  = WINDOW_MASK & 32'hFFFF_FFFC;

  assign legal = ((addr & ~LEGAL_MASK) == 32'd0);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with port-1 lock in front of a 256x32 memory.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int MAX_LOCK  = MAX_LOCK_DEF
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_e       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [1:0]       err_q, err_d;
  logic [31:0]      rdata0_q, rdata0_d;
  logic [31:0]      rdata1_q, rdata1_d;

  logic     legal0, legal1;
  logic     gnt0, gnt1;
  logic     g0, g1;
  logic     lock_reach;
  mem_req_t sel;

  dmem_addr_check #(.ADDR_BITS(ADDR_BITS)) u_chk0 (.addr(bus.m0_addr), .legal(legal0));
  dmem_addr_check #(.ADDR_BITS(ADDR_BITS)) u_chk1 (.addr(bus.m1_addr), .legal(legal1));

  // State, pointer, lock counter and registered responses.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_ARB;
      ptr_q    <= PORT_CPU;
      cnt_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Grant decision, next state, pointer and lock-counter update.
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    lock_reach = 1'b0;
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_ARB: begin
        cnt_d = '0;
        if (bus.m0_req && bus.m1_req) begin
          gnt0 = (ptr_q == PORT_CPU);
          gnt1 = (ptr_q == PORT_AUX);
        end else begin
          gnt0 = bus.m0_req;
          gnt1 = bus.m1_req;
        end
        if (gnt1 && bus.m1_lock) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (bus.m0_req && (cnt_q < CNT_W'(MAX_LOCK))) cnt_d = cnt_q + CNT_W'(1);
        // The cycle in which m0 has waited MAX_LOCK cycles hands it the memory.
        lock_reach = bus.m0_req && (cnt_q >= CNT_W'(MAX_LOCK - 1));
        if (lock_reach) gnt0 = 1'b1;
        else            gnt1 = bus.m1_req;
        if (lock_reach || !bus.m1_req || !bus.m1_lock) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
    // After any grant the other port is favoured next.
    if (gnt0)      ptr_d = PORT_AUX;
    else if (gnt1) ptr_d = PORT_CPU;
  end

  // Memory drive from the granted port and next response values.
  always_comb begin
    g0  = gnt0 & ~reset;
    g1  = gnt1 & ~reset;
    sel = '0;
    if (g0)      sel = '{we: bus.m0_we, addr: bus.m0_addr, wdata: bus.m0_wdata, legal: legal0};
    else if (g1) sel = '{we: bus.m1_we, addr: bus.m1_addr, wdata: bus.m1_wdata, legal: legal1};

    bus.m0_gnt    = g0;
    bus.m1_gnt    = g1;
    bus.mem_addr  = sel.addr;
    bus.mem_wdata = sel.wdata;
    bus.mem_read  = (g0 | g1) & ~sel.we & sel.legal;
    bus.mem_write = (g0 | g1) &  sel.we & sel.legal;

    rvalid_d = {g1, g0};
    err_d    = {g1 & ~legal1, g0 & ~legal0};
    rdata0_d = (g0 && !bus.m0_we && legal0) ? bus.mem_rdata : 32'd0;
    rdata1_d = (g1 && !bus.m1_we && legal1) ? bus.mem_rdata : 32'd0;
  end

  assign bus.m0_rvalid = rvalid_q[0];
  assign bus.m1_rvalid = rvalid_q[1];
  assign bus.m0_err    = err_q[0];
  assign bus.m1_err    = err_q[1];
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural word memory.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] mem [DMEM_WORDS];

  dmem_arbiter_if bus();

  dmem_arbiter #(.ADDR_BITS(10), .MAX_LOCK(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write on the rising edge.
  assign bus.mem_rdata = mem[8'(bus.mem_addr >> 2)];
  always @(posedge clk) begin
    if (bus.mem_write) mem[8'(bus.mem_addr >> 2)] <= bus.mem_wdata;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic lock);
    bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    bus.m1_lock = lock;
  endtask

  task automatic idle();
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    set_m1(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic reset_dut();
    idle();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    #1;
  endtask

  // Reset values, and memory strobes held low while reset is high.
  task automatic test_reset();
    reset = 1'b1;
    set_m0(1'b1, 1'b1, 32'h10, 32'h1234_5678);
    #1;
    total++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.mem_read, bus.mem_write} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_gating: gnt0/gnt1/rd/wr=%b want 0000",
               {bus.m0_gnt, bus.m1_gnt, bus.mem_read, bus.mem_write});
    end
    cyc();
    total++;
    if ({bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err} !== 4'b0000 ||
        bus.m0_rdata !== 32'd0 || bus.m1_rdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: rv0/rv1/err0/err1=%b rdata0=%h rdata1=%h want 0000/0/0",
               {bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err}, bus.m0_rdata, bus.m1_rdata);
    end
    total++;
    if (mem[4] !== 32'd0) begin
      bad++;
      $display("FAIL reset_no_write: mem[4]=%h want 00000000", mem[4]);
    end
    reset_dut();
  endtask

  // Port 0 write then read back through the one-cycle response path.
  task automatic test_write_read();
    set_m0(1'b1, 1'b1, 32'h10, 32'h0000_00AA);
    #1;
    total++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.mem_read, bus.mem_write} !== 4'b1001 ||
        bus.mem_addr !== 32'h10 || bus.mem_wdata !== 32'hAA) begin
      bad++;
      $display("FAIL wr_grant: gnt0/gnt1/rd/wr=%b addr=%h wdata=%h want 1001/10/aa",
               {bus.m0_gnt, bus.m1_gnt, bus.mem_read, bus.mem_write}, bus.mem_addr, bus.mem_wdata);
    end
    cyc();
    set_m0(1'b1, 1'b0, 32'h10, 32'd0);
    #1;
    total++;
    if ({bus.m0_rvalid, bus.m0_err} !== 2'b10 || bus.m0_rdata !== 32'd0) begin
      bad++;
      $display("FAIL wr_resp: rv0/err0=%b rdata0=%h want 10/0", {bus.m0_rvalid, bus.m0_err}, bus.m0_rdata);
    end
    total++;
    if ({bus.m0_gnt, bus.mem_read, bus.mem_write} !== 3'b110) begin
      bad++;
      $display("FAIL rd_grant: gnt0/rd/wr=%b want 110", {bus.m0_gnt, bus.mem_read, bus.mem_write});
    end
    cyc();
    idle();
    #1;
    total++;
    if ({bus.m0_rvalid, bus.m0_err} !== 2'b10 || bus.m0_rdata !== 32'h0000_00AA) begin
      bad++;
      $display("FAIL rd_resp: rv0/err0=%b rdata0=%h want 10/000000aa", {bus.m0_rvalid, bus.m0_err}, bus.m0_rdata);
    end
    cyc();
    total++;
    if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b00) begin
      bad++;
      $display("FAIL rvalid_pulse: rv0/rv1=%b want 00", {bus.m0_rvalid, bus.m1_rvalid});
    end
  endtask

  // Both ports requesting from reset: grants alternate, responses follow by one cycle.
  task automatic test_alternate();
    logic exp0;
    logic prev0;
    reset_dut();
    set_m0(1'b1, 1'b0, 32'h10, 32'd0);
    set_m1(1'b1, 1'b0, 32'h20, 32'd0, 1'b0);
    prev0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp0 = (i % 2 == 0);
      total++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.mem_read, bus.mem_write} !== {exp0, ~exp0, 2'b10}) begin
        bad++;
        $display("FAIL alt_grant[%0d]: gnt0/gnt1/rd/wr=%b want %b", i,
                 {bus.m0_gnt, bus.m1_gnt, bus.mem_read, bus.mem_write}, {exp0, ~exp0, 2'b10});
      end
      if (i > 0) begin
        total++;
        if ({bus.m0_rvalid, bus.m1_rvalid} !== {prev0, ~prev0}) begin
          bad++;
          $display("FAIL alt_rvalid[%0d]: rv0/rv1=%b want %b", i,
                   {bus.m0_rvalid, bus.m1_rvalid}, {prev0, ~prev0});
        end
      end
      prev0 = exp0;
      cyc();
    end
    idle();
    #1;
    total++;
    if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b01 || bus.m1_rdata !== 32'd0) begin
      bad++;
      $display("FAIL alt_last: rv0/rv1=%b rdata1=%h want 01/0", {bus.m0_rvalid, bus.m1_rvalid}, bus.m1_rdata);
    end
    cyc();
  endtask

  // Out-of-range and misaligned requests: granted, no memory access, error response.
  task automatic test_errors();
    set_m1(1'b1, 1'b1, 32'h400, 32'h1234_5678, 1'b0);
    #1;
    total++;
    if ({bus.m1_gnt, bus.mem_read, bus.mem_write} !== 3'b100) begin
      bad++;
      $display("FAIL err_range_grant: gnt1/rd/wr=%b want 100", {bus.m1_gnt, bus.mem_read, bus.mem_write});
    end
    cyc();
    idle();
    set_m0(1'b1, 1'b0, 32'h006, 32'd0);
    #1;
    total++;
    if ({bus.m1_rvalid, bus.m1_err} !== 2'b11 || bus.m1_rdata !== 32'd0) begin
      bad++;
      $display("FAIL err_range_resp: rv1/err1=%b rdata1=%h want 11/0", {bus.m1_rvalid, bus.m1_err}, bus.m1_rdata);
    end
    total++;
    if ({bus.m0_gnt, bus.mem_read, bus.mem_write} !== 3'b100) begin
      bad++;
      $display("FAIL err_align_grant: gnt0/rd/wr=%b want 100", {bus.m0_gnt, bus.mem_read, bus.mem_write});
    end
    cyc();
    idle();
    #1;
    total++;
    if ({bus.m0_rvalid, bus.m0_err} !== 2'b11 || bus.m0_rdata !== 32'd0) begin
      bad++;
      $display("FAIL err_align_resp: rv0/err0=%b rdata0=%h want 11/0", {bus.m0_rvalid, bus.m0_err}, bus.m0_rdata);
    end
    total++;
    if (mem[0] !== 32'd0) begin
      bad++;
      $display("FAIL err_word0: mem[0]=%h want 00000000", mem[0]);
    end
    cyc();
  endtask

  // Port 1 lock starves port 0 until the lock counter forces a hand-over.
  task automatic test_lock();
    set_m1(1'b1, 1'b0, 32'h20, 32'd0, 1'b1);
    #1;
    total++;
    if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL lock_enter: gnt0/gnt1=%b want 01", {bus.m0_gnt, bus.m1_gnt});
    end
    cyc();
    set_m0(1'b1, 1'b0, 32'h10, 32'd0);
    for (int k = 1; k <= 16; k++) begin
      #1;
      total++;
      if ({bus.m0_gnt, bus.m1_gnt} !== ((k < 16) ? 2'b01 : 2'b10)) begin
        bad++;
        $display("FAIL lock_cycle[%0d]: gnt0/gnt1=%b want %b", k,
                 {bus.m0_gnt, bus.m1_gnt}, (k < 16) ? 2'b01 : 2'b10);
      end
      cyc();
    end
    #1;
    total++;
    if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL lock_after: gnt0/gnt1=%b want 01", {bus.m0_gnt, bus.m1_gnt});
    end
    total++;
    if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 32'h0000_00AA) begin
      bad++;
      $display("FAIL lock_m0_resp: rv0=%b rdata0=%h want 1/000000aa", bus.m0_rvalid, bus.m0_rdata);
    end
    cyc();
    idle();
    repeat (2) cyc();
  endtask

  // Asynchronous reset during a granted write: strobe drops at once, nothing lands.
  task automatic test_reset_mid();
    set_m0(1'b1, 1'b1, 32'h84, 32'h0000_0077);
    cyc();
    set_m0(1'b1, 1'b1, 32'h80, 32'h0000_5555);
    #1;
    total++;
    if ({bus.m0_gnt, bus.mem_write, bus.m0_rvalid} !== 3'b111) begin
      bad++;
      $display("FAIL rstmid_pre: gnt0/wr/rv0=%b want 111", {bus.m0_gnt, bus.mem_write, bus.m0_rvalid});
    end
    #1;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.m0_gnt, bus.mem_write, bus.mem_read, bus.m0_rvalid, bus.m1_rvalid} !== 5'b00000) begin
      bad++;
      $display("FAIL rstmid_drop: gnt0/wr/rd/rv0/rv1=%b want 00000",
               {bus.m0_gnt, bus.mem_write, bus.mem_read, bus.m0_rvalid, bus.m1_rvalid});
    end
    cyc();
    total++;
    if (mem[32] !== 32'd0 || mem[33] !== 32'h0000_0077) begin
      bad++;
      $display("FAIL rstmid_mem: mem[32]=%h mem[33]=%h want 00000000/00000077", mem[32], mem[33]);
    end
    reset = 1'b0;
    set_m0(1'b1, 1'b0, 32'h10, 32'd0);
    set_m1(1'b1, 1'b0, 32'h20, 32'd0, 1'b0);
    #1;
    total++;
    if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) begin
      bad++;
      $display("FAIL rstmid_ptr: gnt0/gnt1=%b want 10", {bus.m0_gnt, bus.m1_gnt});
    end
    cyc();
    idle();
    #1;
    total++;
    if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 32'h0000_00AA) begin
      bad++;
      $display("FAIL rstmid_resp: rv0=%b rdata0=%h want 1/000000aa", bus.m0_rvalid, bus.m0_rdata);
    end
    cyc();
  endtask

  // Last word of the window: write via port 1, read back via port 0.
  task automatic test_boundary();
    set_m1(1'b1, 1'b1, 32'h3FC, 32'hDEAD_BEEF, 1'b0);
    #1;
    total++;
    if ({bus.m1_gnt, bus.mem_write} !== 2'b11 || bus.mem_addr !== 32'h3FC) begin
      bad++;
      $display("FAIL bnd_write: gnt1/wr=%b addr=%h want 11/3fc", {bus.m1_gnt, bus.mem_write}, bus.mem_addr);
    end
    cyc();
    idle();
    set_m0(1'b1, 1'b0, 32'h3FC, 32'd0);
    #1;
    total++;
    if ({bus.m1_rvalid, bus.m1_err, bus.m0_gnt, bus.mem_read} !== 4'b1011) begin
      bad++;
      $display("FAIL bnd_wresp: rv1/err1/gnt0/rd=%b want 1011",
               {bus.m1_rvalid, bus.m1_err, bus.m0_gnt, bus.mem_read});
    end
    cyc();
    idle();
    #1;
    total++;
    if ({bus.m0_rvalid, bus.m0_err} !== 2'b10 || bus.m0_rdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL bnd_read: rv0/err0=%b rdata0=%h want 10/deadbeef", {bus.m0_rvalid, bus.m0_err}, bus.m0_rdata);
    end
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    // NOTE: the memory model starts cleared by the bench; real RAM arrays are never reset.
    for (int i = 0; i < DMEM_WORDS; i++) mem[i] = 32'd0;
    idle();
    test_reset();
    test_write_read();
    test_alternate();
    test_errors();
    test_lock();
    test_reset_mid();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
